mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the RISC-V pipeline. It sits between the EX/MEM pipeline register and the write-back stage.
- Loads and stores go through a byte-wide synchronous memory port, one byte per cycle, little-endian, misalignment permitted.
- Non-memory instructions pass straight through in one cycle.
- Produces opcode, destination register and result data for write-back, which is always ready and accepts them combinationally.

Parameters:
- OPW, 11, opcode bus width. [6:0] = RV opcode, [9:7] = funct3, [10] = passed through unmodified.
- XLEN, 32, data/address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept; combinational, equals (state==IDLE)
- opcode_in  in  OPW  instruction opcode/funct3
- Rd_in  in  5  destination register
- alu_result_in  in  XLEN  effective address (load/store) or result (others)
- store_data_in  in  XLEN  rs2 value for stores
- mem_addr  out  XLEN  byte address, registered
- mem_wr  out  1  1 = write byte this cycle, registered
- mem_dout  out  8  write byte, registered
- mem_din  in  8  read byte; valid the cycle after its address is presented
- out_valid  out  1  one-cycle pulse, result valid to write-back
- opcode_out  out  OPW  registered opcode
- Rd_out  out  5  registered Rd; 0 for stores
- data_out  out  XLEN  registered result
- busy  out  1  ~in_ready, for hazard/stall logic

Behaviour:
- Reset: state=IDLE; out_valid, mem_wr, mem_addr, mem_dout, opcode_out, Rd_out, data_out all 0. Byte counter and assembly buffer cleared.
- Reset mid-operation: the in-flight access is abandoned with no out_valid. mem_wr is 0 from the cycle after the reset edge. No further bytes are issued.
- Accept: an instruction is taken at an edge where in_valid & in_ready. While not IDLE, in_valid is ignored; upstream must hold it.
- Classification:
  - Load: opcode 0000011.
  - Store: opcode 0100011.
  - Everything else is pass-through.
- Size from funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 is treated as a word (4 bytes). N = byte count.
- Pass-through, accepted at edge T: out_valid=1 in cycle T+1, data_out=alu_result_in, Rd_out=Rd_in. State stays IDLE, so back-to-back accepts are allowed.
- FSM states: IDLE, ACCESS, LAST.
  - IDLE → ACCESS on accepting a load or store.
    - The stage latches base address, store data, N, signedness, opcode and Rd.
    - Byte counter k=0.
  - ACCESS: in cycle T+1+k, drive mem_addr=base+k (mod 2^32 wrap).
    - Store: mem_wr=1, mem_dout=store_data[8k+7:8k].
    - Load: mem_wr=0.
    - k increments each cycle.
    - Load: the byte on mem_din in cycle T+2+k is written into buffer[8k+7:8k].
  - Leaving ACCESS after issuing byte N-1:
    - Store → IDLE. out_valid=1 in cycle T+N+1, Rd_out=0, data_out=0, mem_wr=0.
    - Load → LAST. mem_wr=0, mem_addr holds.
  - LAST: capture byte N-1, then → IDLE. out_valid=1 in cycle T+N+2.
    - data_out = assembled value, sign-extended (LB/LH) or zero-extended (LBU/LHU) from 8N bits.
- Latency:
  - Pass-through: 1 cycle.
  - Store: N+1 cycles.
  - Load: N+2 cycles.
- out_valid is high for exactly one cycle per instruction. opcode_out/Rd_out/data_out hold until the next result.
- When no byte is being issued, mem_wr=0.

Test Plan:
- Pass-through: ADDI (opcode_in=0x013, Rd=5, alu_result=0x00000123), then back-to-back LUI (Rd=6, 0x12345000) → out_valid in 2 consecutive cycles with (5, 0x123) then (6, 0x12345000). in_ready stays 1.
- LW: mem[0x100..0x103]=78 56 34 12, accepted at T → reads addr 0x100..0x103 in T+1..T+4. out_valid at T+6 with data_out=0x12345678, Rd_out=Rd_in. in_ready=0 during T+1..T+5.
- LB/LBU: mem[0x20]=0x80 → LB gives 0xFFFFFF80, LBU gives 0x00000080. LH of 0xFF,0x7F at 0x31 (misaligned) gives 0x00007FFF.
- SH: addr 0x1001, store_data=0xDEADBEEF → mem_wr=1 with (0x1001, 0xEF) then (0x1002, 0xBE). out_valid with Rd_out=0, data_out=0. Memory otherwise untouched.
- Address wrap: SW at 0xFFFFFFFE → bytes written to 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
- Reset mid-LW after 2 bytes issued → next cycle mem_wr=0, state IDLE, in_ready=1, and out_valid never pulses for the aborted load. A subsequent ADDI completes normally.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: byte-serial, little-endian loads and stores over a
// synchronous byte-wide port; non-memory instructions pass through in one cycle.
module mem_stage #(
    parameter int unsigned OPW  = 11,
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  opcode_in,
    input  logic [4:0]      Rd_in,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic [XLEN-1:0] store_data_in,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_wr,
    output logic [7:0]      mem_dout,
    input  logic [7:0]      mem_din,
    output logic            out_valid,
    output logic [OPW-1:0]  opcode_out,
    output logic [4:0]      Rd_out,
    output logic [XLEN-1:0] data_out,
    output logic            busy
);

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;

    typedef enum logic [1:0] {StIdle, StAccess, StLast} state_t;

    state_t          state_q, state_d;
    logic [1:0]      k_q;        // index of the byte being issued this cycle
    logic [1:0]      last_q;     // N-1
    logic            is_store_q;
    logic            signed_q;
    logic [OPW-1:0]  op_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] sdata_q;    // remaining store bytes, next one in [7:0]
    logic [XLEN-1:0] asm_q;      // load bytes captured so far

    logic            is_load, is_store, is_mem;
    logic [2:0]      funct3;
    logic [1:0]      last_in;
    logic [1:0]      prev_idx;
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] ld_val;

    assign funct3   = opcode_in[9:7];
    assign is_load  = (opcode_in[6:0] == OpLoad);
    assign is_store = (opcode_in[6:0] == OpStore);
    assign is_mem   = is_load | is_store;
    assign in_ready = (state_q == StIdle);
    assign busy     = ~in_ready;
    // mem_din in an ACCESS cycle carries the byte issued one cycle earlier
    assign prev_idx = k_q - 2'd1;

    // Byte count (as N-1) from funct3; unsized encodings fall back to a word
    always_comb begin
        last_in = 2'd3;
        case (funct3)
            3'b000:  last_in = 2'd0;
            3'b001:  last_in = 2'd1;
            3'b100:  last_in = is_load ? 2'd0 : 2'd3;
            3'b101:  last_in = is_load ? 2'd1 : 2'd3;
            default: last_in = 2'd3;
        endcase
    end

    // Merge the final byte straight from mem_din and extend to XLEN
    always_comb begin
        raw = asm_q;
        raw[{last_q, 3'b000} +: 8] = mem_din;
        case (last_q)
            2'd0:    ld_val = {{(XLEN-8){signed_q & raw[7]}}, raw[7:0]};
            2'd1:    ld_val = {{(XLEN-16){signed_q & raw[15]}}, raw[15:0]};
            default: ld_val = raw;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (in_valid && is_mem) state_d = StAccess;
            StAccess: if (k_q == last_q) state_d = is_store_q ? StIdle : StLast;
            StLast:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Datapath: byte issue, load assembly and write-back registers
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q        <= '0;
            last_q     <= '0;
            is_store_q <= 1'b0;
            signed_q   <= 1'b0;
            op_q       <= '0;
            rd_q       <= '0;
            sdata_q    <= '0;
            asm_q      <= '0;
            mem_addr   <= '0;
            mem_wr     <= 1'b0;
            mem_dout   <= '0;
            out_valid  <= 1'b0;
            opcode_out <= '0;
            Rd_out     <= '0;
            data_out   <= '0;
        end else begin
            out_valid <= 1'b0;
            mem_wr    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (in_valid && is_mem) begin
                        // Byte 0 goes out in the first cycle after accept
                        k_q        <= '0;
                        last_q     <= last_in;
                        is_store_q <= is_store;
                        signed_q   <= ~funct3[2];
                        op_q       <= opcode_in;
                        rd_q       <= Rd_in;
                        asm_q      <= '0;
                        sdata_q    <= store_data_in >> 8;
                        mem_addr   <= alu_result_in;
                        mem_wr     <= is_store;
                        mem_dout   <= store_data_in[7:0];
                    end else if (in_valid) begin
                        out_valid  <= 1'b1;
                        opcode_out <= opcode_in;
                        Rd_out     <= Rd_in;
                        data_out   <= alu_result_in;
                    end
                end
                StAccess: begin
                    if (k_q != 2'd0) asm_q[{prev_idx, 3'b000} +: 8] <= mem_din;
                    if (k_q == last_q) begin
                        if (is_store_q) begin
                            out_valid  <= 1'b1;
                            opcode_out <= op_q;
                            Rd_out     <= '0;
                            data_out   <= '0;
                        end
                    end else begin
                        k_q      <= k_q + 2'd1;
                        mem_addr <= mem_addr + XLEN'(1);
                        mem_wr   <= is_store_q;
                        mem_dout <= sdata_q[7:0];
                        sdata_q  <= sdata_q >> 8;
                    end
                end
                StLast: begin
                    out_valid  <= 1'b1;
                    opcode_out <= op_q;
                    Rd_out     <= rd_q;
                    data_out   <= ld_val;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: byte memory model, cycle-level reference model with a
// per-cycle compare process, and directed vectors with literal expectations.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] opcode_in;
    logic [4:0]  Rd_in;
    logic [31:0] alu_result_in;
    logic [31:0] store_data_in;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        out_valid;
    logic [10:0] opcode_out;
    logic [4:0]  Rd_out;
    logic [31:0] data_out;
    logic        busy;

    mem_stage #(.OPW(11), .XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .opcode_in     (opcode_in),
        .Rd_in         (Rd_in),
        .alu_result_in (alu_result_in),
        .store_data_in (store_data_in),
        .mem_addr      (mem_addr),
        .mem_wr        (mem_wr),
        .mem_dout      (mem_dout),
        .mem_din       (mem_din),
        .out_valid     (out_valid),
        .opcode_out    (opcode_out),
        .Rd_out        (Rd_out),
        .data_out      (data_out),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [10:0] op;
        logic [4:0]  rd;
        logic [31:0] data;
    } res_t;

    typedef struct {
        int unsigned cyc;
        logic [31:0] addr;
        logic        wr;
        logic [7:0]  dout;
    } bus_t;

    logic [7:0]  mem     [logic [31:0]];   // memory seen by the DUT
    logic [7:0]  ref_mem [logic [31:0]];   // memory the model expects
    res_t        res_q[$];
    bus_t        bus_q[$];
    res_t        res_log[$];
    int unsigned cyc = 0;
    int unsigned busy_until = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    // Byte-wide synchronous memory: read data appears the cycle after the address
    initial forever begin
        @(posedge clk);
        if (mem_wr === 1'b1) mem[mem_addr] = mem_dout;
        if (!$isunknown(mem_addr)) mem_din <= mem_rd(mem_addr);
        else mem_din <= 8'h00;
    end

    // Reference model: on each accept, schedule the bus cycles and the result
    task automatic model_accept(input int unsigned t);
        logic        ld, st, sgn;
        int          n;
        logic [2:0]  f3;
        logic [31:0] a, val;
        logic [7:0]  b;
        ld  = (opcode_in[6:0] == 7'h03);
        st  = (opcode_in[6:0] == 7'h23);
        f3  = opcode_in[9:7];
        val = 32'h0;
        if (!ld && !st) begin
            res_q.push_back('{t + 1, opcode_in, Rd_in, alu_result_in});
            return;
        end
        n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 :
            (ld && f3 == 3'd4) ? 1 : (ld && f3 == 3'd5) ? 2 : 4;
        sgn = ld && (f3 == 3'd0 || f3 == 3'd1);
        for (int k = 0; k < n; k++) begin
            a = alu_result_in + 32'(k);
            b = 8'(store_data_in >> (8 * k));
            bus_q.push_back('{t + 1 + k, a, st, st ? b : 8'h00});
            if (st) ref_mem[a] = b;
            else val = val | (32'(ref_rd(a)) << (8 * k));
        end
        if (ld) begin
            if (sgn && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
            res_q.push_back('{t + n + 2, opcode_in, Rd_in, val});
            busy_until = t + n + 1;
        end else begin
            res_q.push_back('{t + n + 1, opcode_in, 5'd0, 32'h0});
            busy_until = t + n;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        if (rst) begin
            res_q.delete();
            bus_q.delete();
            busy_until = cyc - 1;
        end else if (in_valid && in_ready) begin
            model_accept(cyc - 1);
        end
    end

    // Per-cycle compare against the model
    initial forever begin
        @(negedge clk);
        if (cyc >= 2) begin
            chk("in_ready", in_ready, cyc > busy_until);
            chk("busy", busy, !(cyc > busy_until));
            if (res_q.size() > 0 && res_q[0].cyc == cyc) begin
                chk("out_valid", out_valid, 1'b1);
                chk("opcode_out", opcode_out, res_q[0].op);
                chk("Rd_out", Rd_out, res_q[0].rd);
                chk("data_out", data_out, res_q[0].data);
                void'(res_q.pop_front());
            end else begin
                chk("out_valid_idle", out_valid, 1'b0);
            end
            if (bus_q.size() > 0 && bus_q[0].cyc == cyc) begin
                chk("mem_addr", mem_addr, bus_q[0].addr);
                chk("mem_wr", mem_wr, bus_q[0].wr);
                if (bus_q[0].wr) chk("mem_dout", mem_dout, bus_q[0].dout);
                void'(bus_q.pop_front());
            end else begin
                chk("mem_wr_idle", mem_wr, 1'b0);
            end
            if (out_valid === 1'b1) res_log.push_back('{cyc, opcode_out, Rd_out, data_out});
        end
    end

    // Present an instruction at a negedge and return at the negedge after it is taken
    task automatic issue(input logic [10:0] op, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] sd);
        int n = 0;
        opcode_in     = op;
        Rd_in         = rd;
        alu_result_in = a;
        store_data_in = sd;
        in_valid      = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'(n), 32'd0);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int nlog;
        rst = 1'b1;
        in_valid = 1'b0;
        opcode_in = '0;
        Rd_in = '0;
        alu_result_in = '0;
        store_data_in = '0;
        mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
        mem[32'h20]  = 8'h80; mem[32'h31]  = 8'hFF; mem[32'h32]  = 8'h7F;
        ref_mem = mem;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_mem_wr", mem_wr, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_dout", mem_dout, 8'h0);
        chk("rst_opcode_out", opcode_out, 11'h0);
        chk("rst_Rd_out", Rd_out, 5'd0);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_in_ready", in_ready, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back pass-through (LUI carries opcode bit 10)
        issue(11'h013, 5'd5, 32'h0000_0123, 32'h0);
        issue(11'h437, 5'd6, 32'h1234_5000, 32'h0);
        idle(3);
        chk("pt_count", res_log.size(), 2);
        chk("pt_consecutive", res_log[1].cyc - res_log[0].cyc, 1);
        chk("pt0_data", res_log[0].data, 32'h0000_0123);
        chk("pt1_rd", res_log[1].rd, 5'd6);

        issue(11'h103, 5'd7, 32'h100, 32'h0);         // LW
        idle(8);
        chk("lw_data", res_log[$].data, 32'h1234_5678);
        chk("lw_rd", res_log[$].rd, 5'd7);
        issue(11'h003, 5'd8, 32'h20, 32'h0);          // LB
        idle(5);
        chk("lb_data", res_log[$].data, 32'hFFFF_FF80);
        issue(11'h203, 5'd9, 32'h20, 32'h0);          // LBU
        idle(5);
        chk("lbu_data", res_log[$].data, 32'h0000_0080);
        issue(11'h083, 5'd10, 32'h31, 32'h0);         // LH, misaligned
        idle(6);
        chk("lh_data", res_log[$].data, 32'h0000_7FFF);

        issue(11'h0A3, 5'd11, 32'h1001, 32'hDEAD_BEEF); // SH
        idle(5);
        chk("sh_rd", res_log[$].rd, 5'd0);
        chk("sh_data", res_log[$].data, 32'h0);
        chk("sh_b0", mem_rd(32'h1001), 8'hEF);
        chk("sh_b1", mem_rd(32'h1002), 8'hBE);
        chk("sh_below", mem_rd(32'h1000), 8'h00);
        chk("sh_above", mem_rd(32'h1003), 8'h00);

        issue(11'h123, 5'd1, 32'hFFFF_FFFE, 32'hA1B2_C3D4); // SW across wrap
        idle(7);
        chk("sw_fe", mem_rd(32'hFFFF_FFFE), 8'hD4);
        chk("sw_ff", mem_rd(32'hFFFF_FFFF), 8'hC3);
        chk("sw_00", mem_rd(32'h0000_0000), 8'hB2);
        chk("sw_01", mem_rd(32'h0000_0001), 8'hA1);

        // Reset after two bytes of a LW have been issued
        nlog = res_log.size();
        issue(11'h103, 5'd12, 32'h100, 32'h0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_mem_wr", mem_wr, 1'b0);
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_busy", busy, 1'b0);
        idle(8);
        chk("abort_no_result", res_log.size(), nlog);
        issue(11'h013, 5'd13, 32'h55, 32'h0);
        idle(3);
        chk("post_abort_data", res_log[$].data, 32'h55);
        chk("post_abort_rd", res_log[$].rd, 5'd13);

        chk("drain_res", res_q.size(), 0);
        chk("drain_bus", bus_q.size(), 0);
        foreach (ref_mem[a]) chk("mem_image", mem_rd(a), ref_mem[a]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
